// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with registered pop data, occupancy count and
// sticky overflow/underflow flags; asynchronous active-high clear.
module lifo_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             wr_en_s;
    logic [AW-1:0]    wr_idx_s;
    logic [AW-1:0]    top_idx_s;
    logic             empty_s, full_s;

    assign empty_s   = (count_q == {(AW+1){1'b0}});
    assign full_s    = (count_q == DEPTH_C);
    // At count==DEPTH the low bits wrap to 0, so top-1 still lands on DEPTH-1.
    assign top_idx_s = count_q[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};

    // Next-state decode for count, pop data, status flags and the storage write.
    always_comb begin
        count_d    = count_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        wr_en_s    = 1'b0;
        wr_idx_s   = count_q[AW-1:0];
        case ({push, pop})
            2'b11: begin
                if (empty_s) begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = {AW{1'b0}};
                    count_d  = {{AW{1'b0}}, 1'b1};
                    udf_d    = 1'b1;
                end else begin
                    dout_d     = mem_q[top_idx_s];
                    dout_vld_d = 1'b1;
                    wr_en_s    = 1'b1;
                    wr_idx_s   = top_idx_s;
                end
            end
            2'b10: begin
                if (full_s) begin
                    ovf_d = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                    count_d = count_q + {{AW{1'b0}}, 1'b1};
                end
            end
            2'b01: begin
                if (empty_s) begin
                    udf_d = 1'b1;
                end else begin
                    dout_d     = mem_q[top_idx_s];
                    dout_vld_d = 1'b1;
                    count_d    = count_q - {{AW{1'b0}}, 1'b1};
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // Control and status registers, cleared asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q    <= {(AW+1){1'b0}};
            dout_q     <= {WIDTH{1'b0}};
            dout_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    // Stack storage; contents are don't-care after clear so it has no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_idx_s] <= din;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign count    = count_q;
    assign empty    = empty_s;
    assign full     = full_s;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_lifo_stack.sv
// Testbench for lifo_stack: directed scenarios plus random push/pop traffic,
// compared against a queue-based stack model.
module tb_lifo_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             clr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic [AW:0]      count;
    logic             empty;
    logic             full;
    logic             ovf;
    logic             udf;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] m_stk[$];
    logic [WIDTH-1:0] m_dout;
    logic             m_vld;
    logic             m_ovf;
    logic             m_udf;

    lifo_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .din      (din),
        .dout     (dout),
        .dout_vld (dout_vld),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .ovf      (ovf),
        .udf      (udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 32'(count), 32'(m_stk.size()));
        check({tag, "_empty"}, 32'(empty), 32'(m_stk.size() == 0));
        check({tag, "_full"},  32'(full),  32'(m_stk.size() == DEPTH));
        check({tag, "_dout"},  32'(dout),  32'(m_dout));
        check({tag, "_vld"},   32'(dout_vld), 32'(m_vld));
        check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
        check({tag, "_udf"},   32'(udf),   32'(m_udf));
    endtask

    task automatic model_clear();
        m_stk.delete();
        m_dout = '0;
        m_vld  = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic o, input logic [WIDTH-1:0] d);
        m_vld = 1'b0;
        if (p && o) begin
            if (m_stk.size() > 0) begin
                m_dout = m_stk[m_stk.size()-1];
                m_stk[m_stk.size()-1] = d;
                m_vld = 1'b1;
            end else begin
                m_stk.push_back(d);
                m_udf = 1'b1;
            end
        end else if (p) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else m_stk.push_back(d);
        end else if (o) begin
            if (m_stk.size() > 0) begin
                m_dout = m_stk.pop_back();
                m_vld  = 1'b1;
            end else begin
                m_udf = 1'b1;
            end
        end
    endtask

    // Apply one operation across a clock edge, then check everything.
    task automatic do_op(input string tag, input logic p, input logic o, input logic [WIDTH-1:0] d);
        push = p;
        pop  = o;
        din  = d;
        @(posedge clk);
        model_step(p, o, d);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    // Clear asserted mid-cycle; outputs must drop without waiting for an edge.
    task automatic do_reset(input string tag);
        #2;
        clr = 1'b1;
        model_clear();
        #1;
        check_all(tag);
        clr = 1'b0;
    endtask

    initial begin
        clr  = 1'b1;
        push = 1'b0;
        pop  = 1'b0;
        din  = '0;
        model_clear();
        #12;
        clr = 1'b0;
        @(posedge clk);
        #1;
        check_all("por");

        // Mid-operation clear with five entries
        for (int i = 0; i < 5; i++) do_op("t1_push", 1'b1, 1'b0, 8'(i + 16));
        check("t1_cnt5", 32'(count), 32'd5);
        do_reset("t1_clr");
        check("t1_cnt0", 32'(count), 32'd0);

        // Ordered pops reverse the pushes
        do_op("t2_push", 1'b1, 1'b0, 8'h01);
        do_op("t2_push", 1'b1, 1'b0, 8'h01);
        do_op("t2_push", 1'b1, 1'b0, 8'h02);
        do_op("t2_push", 1'b1, 1'b0, 8'h03);
        do_op("t2_pop", 1'b0, 1'b1, 8'h00);
        check("t2_first", 32'(dout), 32'h03);
        do_op("t2_idle", 1'b0, 1'b0, 8'h00);
        check("t2_vld_drop", 32'(dout_vld), 32'd0);
        for (int i = 0; i < 3; i++) do_op("t2_pop", 1'b0, 1'b1, 8'h00);
        check("t2_last", 32'(dout), 32'h01);
        check("t2_empty", 32'(empty), 32'd1);

        // Overflow when full is ignored but sticky
        for (int i = 0; i < DEPTH; i++) do_op("t3_fill", 1'b1, 1'b0, 8'(8'h30 + i));
        check("t3_full", 32'(full), 32'd1);
        do_op("t3_ovf", 1'b1, 1'b0, 8'hAA);
        check("t3_ovf_flag", 32'(ovf), 32'd1);
        do_op("t3_pop", 1'b0, 1'b1, 8'h00);
        check("t3_top", 32'(dout), 32'h37);
        do_reset("t3_clr");

        // Underflow from empty, flag stays set
        do_op("t4_udf", 1'b0, 1'b1, 8'h00);
        check("t4_udf_flag", 32'(udf), 32'd1);
        do_op("t4_push", 1'b1, 1'b0, 8'h05);
        do_op("t4_pop", 1'b0, 1'b1, 8'h00);
        check("t4_dout", 32'(dout), 32'h05);
        do_op("t4_pp_empty", 1'b1, 1'b1, 8'h77);
        do_reset("t4_clr");

        // Replace-top
        do_op("t5_push", 1'b1, 1'b0, 8'h01);
        do_op("t5_push", 1'b1, 1'b0, 8'h02);
        do_op("t5_rep", 1'b1, 1'b1, 8'h03);
        check("t5_rep_dout", 32'(dout), 32'h02);
        do_op("t5_pop", 1'b0, 1'b1, 8'h00);
        check("t5_new_top", 32'(dout), 32'h03);
        do_reset("t5_clr");

        // Replace-top on a full stack, then clear across a pop edge
        for (int i = 0; i < DEPTH; i++) do_op("t6_fill", 1'b1, 1'b0, 8'(8'h40 + i));
        do_op("t6_rep", 1'b1, 1'b1, 8'h55);
        check("t6_no_ovf", 32'(ovf), 32'd0);
        check("t6_rep_dout", 32'(dout), 32'h47);
        pop = 1'b1;
        #7;
        clr = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        check_all("t6_clr_pop");
        pop = 1'b0;
        clr = 1'b0;

        // Random traffic with occasional clears
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset("rnd_clr");
            end else begin
                do_op("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      8'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
